// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick shift-register scanner.
package joy_pkg;

    localparam int unsigned JOY_W      = 12;
    localparam int unsigned FRAME_BITS = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT,
        GAP,
        COMMIT
    } joy_state_e;

    // Serial bit k lands at this index of {joystick2, joystick1}: j1 bit b -> b, j2 bit b -> 12+b.
    localparam logic [4:0] JOY_BIT_MAP [FRAME_BITS] = '{
        5'd8,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0,
        5'd20, 5'd18, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12,
        5'd22, 5'd23, 5'd21, 5'd19,
        5'd10, 5'd11, 5'd9,  5'd7
    };

endpackage

// File: rtl/joy_tick_gen.sv
// Prescaler and shift-clock generator with rise/fall strobes aligned to the toggling tick.
module joy_tick_gen #(
    parameter int unsigned DIV_HALF = 16
) (
    input  logic clk_24,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o,
    output logic joy_clk_o
);

    localparam logic [7:0] TopCnt = 8'(DIV_HALF - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       clk_q, clk_d;

    always_comb begin
        tick_o = (cnt_q == TopCnt);
        cnt_d  = (tick_o || clear_i) ? 8'd0 : cnt_q + 8'd1;
        rise_o = tick_o && run_i && !clk_q;
        fall_o = tick_o && run_i && clk_q;
        if (!run_i) begin
            clk_d = 1'b0;
        end else if (tick_o) begin
            clk_d = ~clk_q;
        end else begin
            clk_d = clk_q;
        end
    end

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign joy_clk_o = clk_q;

endmodule

// File: rtl/joy_scan_ctrl.sv
// Joystick frame sequencer: loads, shifts in 24 bits, filters repeated frames and
// publishes two active-low 12-bit words only at commit time.
module joy_scan_ctrl
    import joy_pkg::*;
#(
    parameter int unsigned DIV_HALF     = 16,
    parameter int unsigned MATCH_FRAMES = 2
) (
    input  logic             clk_24,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             joy_data_i,
    output logic             joy_clk_o,
    output logic             joy_load_o,
    output logic [JOY_W-1:0] joystick1_o,
    output logic [JOY_W-1:0] joystick2_o,
    output logic             frame_done_o,
    output logic             update_o
);

    localparam logic [1:0] MatchThr = 2'(MATCH_FRAMES);
    localparam logic [4:0] LastBit  = 5'(FRAME_BITS - 1);

    joy_state_e              state_q;
    logic                    load_q, done_q, upd_q;
    logic [4:0]              bit_q;
    logic [FRAME_BITS-1:0]   cap_q, prev_q;
    logic [1:0]              match_q, match_d;
    logic [2*JOY_W-1:0]      joy_q, cap_word;
    logic [1:0]              sync_q;
    logic                    tick, rise, fall, run, clear;

    assign run   = state_q inside {LOAD, SETTLE, SHIFT, GAP};
    assign clear = (state_q == COMMIT);

    joy_tick_gen #(
        .DIV_HALF (DIV_HALF)
    ) u_tick_gen (
        .clk_24    (clk_24),
        .reset     (reset),
        .run_i     (run),
        .clear_i   (clear),
        .tick_o    (tick),
        .rise_o    (rise),
        .fall_o    (fall),
        .joy_clk_o (joy_clk_o)
    );

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], joy_data_i};
        end
    end

    always_comb begin
        cap_word = '1;
        for (int k = 0; k < FRAME_BITS; k++) begin
            cap_word[JOY_BIT_MAP[k]] = cap_q[k];
        end
    end

    always_comb begin
        if (cap_q == prev_q) begin
            match_d = (match_q == 2'd3) ? 2'd3 : match_q + 2'd1;
        end else begin
            match_d = 2'd1;
        end
    end

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            load_q  <= 1'b1;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            bit_q   <= 5'd0;
            cap_q   <= '1;
            prev_q  <= '1;
            match_q <= 2'd0;
            joy_q   <= '1;
        end else begin
            done_q <= 1'b0;
            upd_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tick && enable_i) begin
                        state_q <= LOAD;
                        load_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (fall) begin
                        state_q <= SETTLE;
                        load_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (fall) begin
                        state_q <= SHIFT;
                        bit_q   <= 5'd0;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        cap_q[bit_q] <= sync_q[1];
                    end
                    if (fall) begin
                        if (bit_q == LastBit) begin
                            state_q <= GAP;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end
                GAP: begin
                    if (fall) begin
                        state_q <= COMMIT;
                        done_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    match_q <= match_d;
                    prev_q  <= cap_q;
                    if (match_d >= MatchThr && cap_word != joy_q) begin
                        joy_q <= cap_word;
                        upd_q <= 1'b1;
                    end
                    if (enable_i) begin
                        state_q <= LOAD;
                        load_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign joy_load_o   = load_q;
    assign frame_done_o = done_q;
    assign update_o     = upd_q;
    assign joystick1_o  = joy_q[JOY_W-1:0];
    assign joystick2_o  = joy_q[2*JOY_W-1:JOY_W];

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Randomized scoreboard bench for joy_scan_ctrl with a behavioural shift-register model.
module tb_joy_scan_ctrl;

    localparam int unsigned DivHalf     = 16;
    localparam int unsigned MatchFrames = 2;

    // Destination (player, button) of serial bit k, straight from the bit map table.
    localparam int MapPlayer [24] = '{0, 0, 0, 0, 0, 0, 0, 0,
                                      1, 1, 1, 1, 1, 1, 1, 1,
                                      1, 1, 1, 1, 0, 0, 0, 0};
    localparam int MapButton [24] = '{8, 6, 5, 4, 3, 2, 1, 0,
                                      8, 6, 5, 4, 3, 2, 1, 0,
                                      10, 11, 9, 7, 10, 11, 9, 7};

    logic        clk_24 = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic        joy_data_i = 1'b1;
    logic        joy_clk_o, joy_load_o, frame_done_o, update_o;
    logic [11:0] joystick1_o, joystick2_o;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] pat_q [$];
    logic [24:0] exp_q [$];
    logic [23:0] frame = '1;
    logic [23:0] m_prev = '1;
    logic [23:0] m_out = '1;
    int          m_cnt = 0;
    int          rises = 0;
    bit          loaded = 1'b0;
    bit          chk_next = 1'b0;
    logic [24:0] exp_cur;

    joy_scan_ctrl #(
        .DIV_HALF     (DivHalf),
        .MATCH_FRAMES (MatchFrames)
    ) dut (
        .clk_24       (clk_24),
        .reset        (reset),
        .enable_i     (enable_i),
        .joy_data_i   (joy_data_i),
        .joy_clk_o    (joy_clk_o),
        .joy_load_o   (joy_load_o),
        .joystick1_o  (joystick1_o),
        .joystick2_o  (joystick2_o),
        .frame_done_o (frame_done_o),
        .update_o     (update_o)
    );

    always #5 clk_24 = ~clk_24;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [23:0] to_words(input logic [23:0] f);
        logic [11:0] w [2];
        w[0] = '1;
        w[1] = '1;
        for (int k = 0; k < 24; k++) w[MapPlayer[k]][MapButton[k]] = f[k];
        return {w[1], w[0]};
    endfunction

    function automatic logic [23:0] rand_frame();
        logic [23:0] p = '1;
        repeat ($urandom_range(1, 3)) p[$urandom_range(0, 23)] = 1'b0;
        return p;
    endfunction

    // External register: latches a pattern on load, presents bit n after the (n+1)-th
    // rising shift clock; the reference filter runs once per launched frame.
    always @(negedge joy_load_o or posedge joy_clk_o or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_prev = '1;
            m_out = '1;
            m_cnt = 0;
            rises = 0;
            loaded = 1'b0;
            joy_data_i = 1'b1;
        end else if (joy_load_o === 1'b0) begin
            if (!loaded) begin
                logic [23:0] w;
                bit          upd;
                loaded = 1'b1;
                rises = 0;
                if (pat_q.size() > 0) begin
                    frame = pat_q.pop_front();
                end else begin
                    case ($urandom_range(0, 3))
                        2:       frame = rand_frame();
                        3:       frame = '1;
                        default: frame = frame;
                    endcase
                end
                m_cnt = (frame == m_prev) ? ((m_cnt < 3) ? m_cnt + 1 : 3) : 1;
                m_prev = frame;
                w = to_words(frame);
                upd = (m_cnt >= MatchFrames) && (w != m_out);
                if (upd) m_out = w;
                exp_q.push_back({upd, m_out});
            end
        end else begin
            loaded = 1'b0;
            if (joy_clk_o === 1'b1) begin
                rises++;
                joy_data_i = (rises >= 1 && rises <= 24) ? frame[rises-1] : 1'b1;
            end
        end
    end

    // Monitor: each frame_done pops an expectation, checked on the following (commit) cycle.
    always @(negedge clk_24) begin
        if (reset) begin
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk_next = 1'b0;
                check("update_pulse", update_o, exp_cur[24]);
                check("joystick1", joystick1_o, exp_cur[11:0]);
                check("joystick2", joystick2_o, exp_cur[23:12]);
            end else if (update_o !== 1'b0) begin
                check("update_outside_commit", update_o, 1'b0);
            end
            if (frame_done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("frame_done_unexpected", frame_done_o, 1'b0);
                end else begin
                    exp_cur = exp_q.pop_front();
                    chk_next = 1'b1;
                end
            end
        end
    end

    task automatic wait_frame();
        int c = 0;
        while (frame_done_o !== 1'b1 && c < 2000) begin
            @(posedge clk_24);
            #1;
            c++;
        end
        check("frame_done_seen", frame_done_o, 1'b1);
        @(posedge clk_24);
        #1;
    endtask

    task automatic wait_rise(input int n);
        int c = 0;
        while (rises != n && c < 3000) begin
            @(posedge clk_24);
            #1;
            c++;
        end
        check("shift_position_reached", rises, n);
    endtask

    task automatic measure_load(input string nm);
        int n = 0;
        while (joy_load_o === 1'b1 && n < 200) begin
            @(posedge clk_24);
            #1;
            n++;
        end
        check({nm, "_load_start"}, n, DivHalf);
        n = 0;
        while (joy_load_o === 1'b0 && n < 200) begin
            @(posedge clk_24);
            #1;
            n++;
        end
        check({nm, "_load_width"}, n, 2 * DivHalf);
    endtask

    initial begin
        int c;
        int viol;
        pat_q.push_back(24'hDFFFEF);
        pat_q.push_back(24'hDFFFEF);
        pat_q.push_back(24'hFFEFFF);
        pat_q.push_back(24'hFFFFFF);
        pat_q.push_back(24'hFFFFFF);
        pat_q.push_back(24'hFFEFFF);
        pat_q.push_back(24'hFFEFFF);

        repeat (3) @(posedge clk_24);
        #1;
        check("rst_joy_clk", joy_clk_o, 1'b0);
        check("rst_joy_load", joy_load_o, 1'b1);
        check("rst_joystick1", joystick1_o, 12'hFFF);
        check("rst_joystick2", joystick2_o, 12'hFFF);
        check("rst_frame_done", frame_done_o, 1'b0);
        check("rst_update", update_o, 1'b0);

        enable_i = 1'b1;
        @(negedge clk_24);
        reset = 1'b0;
        measure_load("first");
        c = 2 * DivHalf;
        while (frame_done_o !== 1'b1 && c < 2000) begin
            @(posedge clk_24);
            #1;
            c++;
        end
        check("first_frame_done_time", c, 54 * DivHalf);
        @(posedge clk_24);
        #1;

        repeat (22) wait_frame();

        // Drop enable partway through the shift; the frame must still complete.
        wait_rise(12);
        enable_i = 1'b0;
        wait_frame();
        viol = 0;
        repeat (500) begin
            @(posedge clk_24);
            #1;
            if (joy_clk_o !== 1'b0 || joy_load_o !== 1'b1 || frame_done_o !== 1'b0) viol++;
        end
        check("idle_pins_quiet", viol, 0);
        check("idle_outputs_hold", {joystick2_o, joystick1_o}, m_out);

        // Commit a non-idle word, then reset in the middle of the next shift.
        repeat (3) pat_q.push_back(24'hDFFFEF);
        enable_i = 1'b1;
        wait_frame();
        wait_frame();
        wait_rise(17);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_joystick1", joystick1_o, 12'hFFF);
        check("midreset_joystick2", joystick2_o, 12'hFFF);
        check("midreset_joy_load", joy_load_o, 1'b1);
        check("midreset_joy_clk", joy_clk_o, 1'b0);
        repeat (2) @(posedge clk_24);
        @(negedge clk_24);
        reset = 1'b0;
        measure_load("after_reset");

        repeat (4) wait_frame();
        enable_i = 1'b0;
        wait_frame();
        repeat (100) @(posedge clk_24);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_outputs", {joystick2_o, joystick1_o}, m_out);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
